mmio_console: RTL and testbench



---
 rtl/mmio_console_pkg.sv | 39 +++
 rtl/mmio_console_if.sv | 23 ++
 rtl/console_fifo.sv | 55 +++++
 rtl/mmio_console.sv | 168 ++++++++++++++++
 tb/tb_mmio_console.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_console_pkg.sv
// Shared offsets, cause codes and status layout for the MMIO console.
package mmio_console_pkg;

    localparam logic [31:0] OFS_HALT      = 32'h0000_0000;
    localparam logic [31:0] OFS_WDT       = 32'h0000_0004;
    localparam logic [31:0] OFS_CH_STRIDE = 32'h0000_0100;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_SW   = 2'd1,
        CAUSE_WDT  = 2'd2
    } cause_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    localparam int STAT_SPACE = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_CNT   = 8;

    function automatic logic [31:0] ch_status(
        input logic [7:0] cnt,
        input logic       ovf,
        input logic       empty,
        input logic       full
    );
        logic [31:0] s;
        s = '0;
        s[STAT_CNT +: 8] = cnt;
        s[STAT_OVF]      = ovf;
        s[STAT_EMPTY]    = empty;
        s[STAT_SPACE]    = ~full;
        return s;
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// MMIO bus plus per-channel TX byte streams of the console.
interface mmio_console_if #(
    parameter int NCH = 2
);
    logic             mmio_oe;
    logic [3:0]       mmio_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic [NCH-1:0]   tx_valid;
    logic [NCH*8-1:0] tx_data;
    logic [NCH-1:0]   tx_ready;

    modport master (
        output mmio_oe, mmio_we, mem_addr, mem_wdata, tx_ready,
        input  mem_rdata, tx_valid, tx_data
    );

    modport slave (
        input  mmio_oe, mmio_we, mem_addr, mem_wdata, tx_ready,
        output mem_rdata, tx_valid, tx_data
    );
endinterface

// File: rtl/console_fifo.sv
// Byte FIFO for one TX channel with sticky overflow flag.
module console_fifo
    import mmio_console_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          ovf_clr,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mmio_console.sv
// MMIO console: NCH buffered TX channels, sticky halt register, watchdog.
// Watchdog present only when MMIO_CONSOLE_WDT_EN is defined.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hf000_0000
) (
    input  logic               clk,
    input  logic               rst,
    mmio_console_if.slave      bus,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [31:0]        halt_code
);
    localparam int          CW   = $clog2(DEPTH + 1);
    localparam logic [31:0] SPAN = 32'(NCH) * OFS_CH_STRIDE + 32'd4;

    logic [31:0]    offset;
    logic           hit;
    logic           sel_halt;
    logic [NCH-1:0] sel_ch;
    logic           wr_en;
    logic           rd_en;
    logic           sw_halt;
    logic           wdt_fire;

    logic [7:0]     dout  [NCH];
    logic [CW-1:0]  count [NCH];
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] ovf;

    state_e         state;
    state_e         state_nxt;
    cause_e         cause_q;
    cause_e         cause_nxt;
    logic [31:0]    code_q;
    logic [31:0]    code_nxt;
    logic [31:0]    rdata_q;
    logic [31:0]    rdata_nxt;
    logic           unused;

    assign offset   = bus.mem_addr - BASE_ADDR;
    assign hit      = offset < SPAN;
    assign sel_halt = hit && (offset[31:2] == OFS_HALT[31:2]);
    assign wr_en    = bus.mmio_oe & bus.mmio_we[0] & hit & ~halted;
    assign rd_en    = bus.mmio_oe & ~bus.mmio_we[0] & hit;
    assign sw_halt  = wr_en & sel_halt;
    assign unused   = ^{offset[1:0], bus.mmio_we[3:1]};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [31:0] CH_OFS = 32'(c + 1) * OFS_CH_STRIDE;

        assign sel_ch[c] = hit && (offset[31:2] == CH_OFS[31:2]);

        console_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (wr_en & sel_ch[c]),
            .din      (bus.mem_wdata[7:0]),
            .pop      (~empty[c] & bus.tx_ready[c]),
            .ovf_clr  (rd_en & sel_ch[c]),
            .dout     (dout[c]),
            .full     (full[c]),
            .empty    (empty[c]),
            .count    (count[c]),
            .overflow (ovf[c])
        );
    end

    always_comb begin
        bus.tx_valid = '0;
        bus.tx_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            bus.tx_valid[c]       = ~empty[c];
            bus.tx_data[c*8 +: 8] = dout[c];
        end
    end

`ifdef MMIO_CONSOLE_WDT_EN
    logic        sel_wdt;
    logic        wdt_on;
    logic [31:0] wdt_limit;
    logic [31:0] wdt_cnt;

    assign sel_wdt  = hit && (offset[31:2] == OFS_WDT[31:2]);
    assign wdt_on   = (wdt_limit != '0) && !halted;
    assign wdt_fire = wdt_on && (wdt_cnt == wdt_limit - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_limit <= '0;
            wdt_cnt   <= '0;
        end else if (wr_en && sel_wdt) begin
            wdt_limit <= bus.mem_wdata;
            wdt_cnt   <= '0;
        end else if (wdt_on) begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            cause_q <= CAUSE_NONE;
            code_q  <= '0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            code_q  <= code_nxt;
        end
    end

    // Software halt outranks a coincident watchdog expiry.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        code_nxt  = code_q;
        unique case (state)
            ST_RUN: begin
                if (sw_halt) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_SW;
                    code_nxt  = bus.mem_wdata;
                end else if (wdt_fire) begin
                    state_nxt = ST_HALTED;
                    cause_nxt = CAUSE_WDT;
                    code_nxt  = 32'hffff_ffff;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_HALTED;
        endcase
    end

    assign halted     = (state == ST_HALTED);
    assign halt_cause = 2'(cause_q);
    assign halt_code  = code_q;

    always_comb begin
        rdata_nxt = '0;
        if (sel_halt) rdata_nxt = {29'b0, 2'(cause_q), halted};
`ifdef MMIO_CONSOLE_WDT_EN
        if (sel_wdt) rdata_nxt = wdt_limit;
`endif
        for (int c = 0; c < NCH; c++) begin
            if (sel_ch[c]) begin
                rdata_nxt = ch_status(8'(count[c]), ovf[c],
                                      empty[c], full[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= rdata_nxt;
    end

    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console (NCH=2, DEPTH=16).
module tb_mmio_console;
    localparam int          NCH   = 2;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hf000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] halt_code;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    mmio_console_if #(.NCH(NCH)) bus ();

    mmio_console #(
        .NCH       (NCH),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .halted     (halted),
        .halt_cause (halt_cause),
        .halt_code  (halt_code)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mmio_oe   = 1'b1;
        bus.mmio_we   = 4'hf;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        cyc();
        bus.mmio_oe = 1'b0;
        bus.mmio_we = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.mmio_oe  = 1'b1;
        bus.mmio_we  = 4'h0;
        bus.mem_addr = a;
        cyc();
        bus.mmio_oe = 1'b0;
        d = bus.mem_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        cyc();
        cyc();
        total++;
        if ({halted, halt_cause, halt_code} !== 35'h0)
            $display("FAIL reset_halt got %b/%0d/%h want 0/0/0",
                     halted, halt_cause, halt_code);
        else passed++;
        total++;
        if (bus.tx_valid !== 2'b00)
            $display("FAIL reset_txv got %b want 00", bus.tx_valid);
        else passed++;
        total++;
        if (bus.mem_rdata !== 32'h0)
            $display("FAIL reset_rdata got %h want 0", bus.mem_rdata);
        else passed++;
        rst = 1'b0;
        cyc();
        rd(BASE + 32'h100, d);
        total++;
        if (d !== 32'h3) $display("FAIL reset_st0 got %h want 3", d);
        else passed++;
        rd(BASE, d);
        total++;
        if (d !== 32'h0) $display("FAIL reset_haltrd got %h want 0", d);
        else passed++;
    endtask

    task automatic test_ch1_order();
        logic [31:0] d;
        bus.tx_ready = 2'b10;
        wr(BASE + 32'h200, 32'h41);
        total++;
        if ({bus.tx_valid, bus.tx_data[15:8]} !== {2'b10, 8'h41})
            $display("FAIL ch1_first got %b/%h want 10/41",
                     bus.tx_valid, bus.tx_data[15:8]);
        else passed++;
        wr(BASE + 32'h200, 32'h42);
        total++;
        if ({bus.tx_valid, bus.tx_data[15:8]} !== {2'b10, 8'h42})
            $display("FAIL ch1_second got %b/%h want 10/42",
                     bus.tx_valid, bus.tx_data[15:8]);
        else passed++;
        cyc();
        total++;
        if (bus.tx_valid !== 2'b00)
            $display("FAIL ch1_drain got %b want 00", bus.tx_valid);
        else passed++;
        rd(BASE + 32'h200, d);
        total++;
        if (d !== 32'h3) $display("FAIL ch1_status got %h want 3", d);
        else passed++;
        bus.tx_ready = 2'b00;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        bus.tx_ready = 2'b00;
        for (int i = 0; i <= DEPTH; i++) wr(BASE + 32'h100, 32'h10 + i);
        rd(BASE + 32'h100, d);
        total++;
        if (d !== 32'h1004) $display("FAIL ovf_st1 got %h want 1004", d);
        else passed++;
        rd(BASE + 32'h100, d);
        total++;
        if (d !== 32'h1000) $display("FAIL ovf_st2 got %h want 1000", d);
        else passed++;
        total++;
        if ({bus.tx_valid[0], bus.tx_data[7:0]} !== {1'b1, 8'h10})
            $display("FAIL ovf_head got %b/%h want 1/10",
                     bus.tx_valid[0], bus.tx_data[7:0]);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [7:0]  exp;
        bus.tx_ready = 2'b01;
        wr(BASE + 32'h100, 32'h77);
        bus.tx_ready = 2'b00;
        rd(BASE + 32'h100, d);
        total++;
        if (d !== 32'h1000) $display("FAIL fpp_status got %h want 1000", d);
        else passed++;
        bus.tx_ready = 2'b01;
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'h77;
            total++;
            if ({bus.tx_valid[0], bus.tx_data[7:0]} !== {1'b1, exp})
                $display("FAIL fpp_byte%0d got %b/%h want 1/%h", i,
                         bus.tx_valid[0], bus.tx_data[7:0], exp);
            else passed++;
            cyc();
        end
        total++;
        if (bus.tx_valid !== 2'b00)
            $display("FAIL fpp_empty got %b want 00", bus.tx_valid);
        else passed++;
        bus.tx_ready = 2'b00;
    endtask

    task automatic test_wdt();
        logic [31:0] d;
`ifdef MMIO_CONSOLE_WDT_EN
        wr(BASE + 32'h4, 32'd100);
        repeat (99) cyc();
        total++;
        if (halted !== 1'b0) $display("FAIL wdt_early got %b want 0", halted);
        else passed++;
        cyc();
        total++;
        if ({halted, halt_cause, halt_code} !== {1'b1, 2'd2, 32'hffffffff})
            $display("FAIL wdt_fire got %b/%0d/%h want 1/2/ffffffff",
                     halted, halt_cause, halt_code);
        else passed++;
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'd100) $display("FAIL wdt_limit got %h want 64", d);
        else passed++;
        rd(BASE, d);
        total++;
        if (d !== 32'h5) $display("FAIL wdt_haltrd got %h want 5", d);
        else passed++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
`else
        wr(BASE + 32'h4, 32'd100);
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'h0) $display("FAIL wdt_rd got %h want 0", d);
        else passed++;
        repeat (150) cyc();
        total++;
        if ({halted, halt_cause} !== 3'b000)
            $display("FAIL wdt_off got %b/%0d want 0/0", halted, halt_cause);
        else passed++;
`endif
    endtask

    task automatic test_halt();
        logic [31:0] d;
        bus.tx_ready = 2'b00;
        wr(BASE, 32'h2a);
        total++;
        if ({halted, halt_cause, halt_code} !== {1'b1, 2'd1, 32'h2a})
            $display("FAIL halt_sw got %b/%0d/%h want 1/1/2a",
                     halted, halt_cause, halt_code);
        else passed++;
        rd(BASE, d);
        total++;
        if (d !== 32'h3) $display("FAIL halt_rd got %h want 3", d);
        else passed++;
        rd(BASE + 32'h80, d);
        total++;
        if (d !== 32'h0) $display("FAIL halt_undec got %h want 0", d);
        else passed++;
        wr(BASE, 32'h99);
        total++;
        if ({halt_cause, halt_code} !== {2'd1, 32'h2a})
            $display("FAIL halt_rewr got %0d/%h want 1/2a",
                     halt_cause, halt_code);
        else passed++;
        wr(BASE + 32'h100, 32'h55);
        total++;
        if (bus.tx_valid !== 2'b00)
            $display("FAIL halt_push got %b want 00", bus.tx_valid);
        else passed++;
        rd(BASE + 32'h100, d);
        total++;
        if (d !== 32'h3) $display("FAIL halt_st got %h want 3", d);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.tx_ready = 2'b00;
        for (int i = 0; i < 5; i++) wr(BASE + 32'h200, 32'h61 + i);
        rd(BASE + 32'h200, d);
        total++;
        if (d !== 32'h501) $display("FAIL mid_st got %h want 501", d);
        else passed++;
        wr(BASE, 32'h7);
        total++;
        if (halted !== 1'b1) $display("FAIL mid_halt got %b want 1", halted);
        else passed++;
        bus.tx_ready = 2'b10;
        rst = 1'b1;
        cyc();
        total++;
        if ({halted, halt_cause, halt_code} !== 35'h0)
            $display("FAIL mid_rst_halt got %b/%0d/%h want 0/0/0",
                     halted, halt_cause, halt_code);
        else passed++;
        total++;
        if ({bus.tx_valid, bus.mem_rdata} !== 34'h0)
            $display("FAIL mid_rst_out got %b/%h want 00/0",
                     bus.tx_valid, bus.mem_rdata);
        else passed++;
        rst = 1'b0;
        bus.tx_ready = 2'b00;
        rd(BASE + 32'h200, d);
        total++;
        if (d !== 32'h3) $display("FAIL mid_st2 got %h want 3", d);
        else passed++;
    endtask

    initial begin
        bus.mmio_oe   = 1'b0;
        bus.mmio_we   = 4'h0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.tx_ready  = 2'b00;
        test_reset();
        test_ch1_order();
        test_overflow();
        test_full_push_pop();
        test_wdt();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule
